// File: rtl/core_pkg.sv
// Shared types and constants for the memory-access stage.
package core_pkg;

  typedef enum logic [3:0] {
    OpNone = 4'd0,
    OpLb   = 4'd1,
    OpLh   = 4'd2,
    OpLw   = 4'd3,
    OpLbu  = 4'd4,
    OpLhu  = 4'd5,
    OpSb   = 4'd6,
    OpSh   = 4'd7,
    OpSw   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_t;

  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  function automatic logic is_store(mem_op_t op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  function automatic logic is_load(mem_op_t op);
    return (op == OpLb) || (op == OpLh) || (op == OpLw) || (op == OpLbu) || (op == OpLhu);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replication, load lane select and extension,
// and alignment checking.
module mem_lane_align
  import core_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb      = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    misaligned = 1'b0;
    case (mem_op_t'(op))
      OpLb:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      OpLbu: rdata_ext = {24'h0, byte_sel};
      OpLh: begin
        misaligned = addr[0];
        rdata_ext  = {{16{half_sel[15]}}, half_sel};
      end
      OpLhu: begin
        misaligned = addr[0];
        rdata_ext  = {16'h0, half_sel};
      end
      OpLw: begin
        misaligned = (addr != 2'b00);
        rdata_ext  = rdata;
      end
      OpSb: begin
        wstrb      = WSTRB_BYTE << addr;
        wdata_lane = {4{wdata[7:0]}};
      end
      OpSh: begin
        misaligned = addr[0];
        wstrb      = addr[1] ? (WSTRB_HALF << 2) : WSTRB_HALF;
        wdata_lane = {2{wdata[15:0]}};
      end
      OpSw: begin
        misaligned = (addr != 2'b00);
        wstrb      = WSTRB_WORD;
        wdata_lane = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one packet in flight, req/ack data-memory access with timeout,
// registered writeback packet held until accepted.
module mem_stage
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic [31:0]       out_data,
  output logic              out_wen,
  output logic              out_err
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q;
  logic [3:0]       op_q;
  logic [1:0]       addr_lo_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic [3:0]  align_op;
  logic [1:0]  align_addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;
  logic        misaligned;

  // In IDLE the aligner decodes the incoming packet; afterwards the latched one.
  assign align_op   = (state_q == StIdle) ? in_op : op_q;
  assign align_addr = (state_q == StIdle) ? in_addr[1:0] : addr_lo_q;

  mem_lane_align u_align (
    .op         (align_op),
    .addr       (align_addr),
    .wdata      (in_wdata),
    .rdata      (mem_rdata),
    .wstrb      (wstrb),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= 4'h0;
      addr_lo_q <= 2'b00;
      rd_q      <= 5'd0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
      out_valid <= 1'b0;
      out_rd    <= 5'd0;
      out_data  <= 32'h0;
      out_wen   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            op_q      <= in_op;
            addr_lo_q <= in_addr[1:0];
            rd_q      <= in_rd;
            out_rd    <= in_rd;
            cnt_q     <= '0;
            out_err   <= 1'b0;
            if (!is_load(mem_op_t'(in_op)) && !is_store(mem_op_t'(in_op))) begin
              state_q   <= StResp;
              out_valid <= 1'b1;
              out_data  <= 32'(in_addr);
              out_wen   <= (in_rd != 5'd0);
            end else if (misaligned) begin
              state_q   <= StResp;
              out_valid <= 1'b1;
              out_data  <= 32'h0;
              out_wen   <= 1'b0;
              out_err   <= 1'b1;
            end else begin
              state_q   <= StAccess;
              mem_req   <= 1'b1;
              mem_we    <= is_store(mem_op_t'(in_op));
              mem_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= wdata_lane;
              mem_wstrb <= wstrb;
            end
          end
        end
        StAccess: begin
          if (mem_ack) begin
            state_q   <= StResp;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            out_valid <= 1'b1;
            if (is_load(mem_op_t'(op_q))) begin
              out_data <= rdata_ext;
              out_wen  <= (rd_q != 5'd0);
            end else begin
              out_data <= 32'h0;
              out_wen  <= 1'b0;
            end
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_q   <= StResp;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            out_valid <= 1'b1;
            out_data  <= 32'h0;
            out_wen   <= 1'b0;
            out_err   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StResp: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset-in-flight sequence,
// and randomized packets checked against a byte-level reference model.
module tb_mem_stage;
  import core_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        out_valid, out_ready, out_wen, out_err;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req) req_cycles <= req_cycles + 1;

  mem_stage #(.ADDR_W(32), .MEM_TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .in_rd     (in_rd),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .out_wen   (out_wen),
    .out_err   (out_err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          ack_dly;
    int          rdy_dly;
    bit          exp_mem;
    bit          exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_mwdata;
    bit          chk_data;
    logic [31:0] exp_data;
    bit          exp_wen;
    bit          exp_err;
  } vec_t;

  task automatic check(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", tag, what, act, exp);
    end
  endtask

  // Reference model: operand size and byte lane drive everything.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd,
                                 input logic [31:0] rdata, input int ack_dly,
                                 input int rdy_dly);
    vec_t v;
    int size, lane;
    bit store, signd;
    logic [31:0] val;
    v = '{op, addr, wdata, rd, rdata, ack_dly, rdy_dly, 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 0};
    case (op)
      1: begin size = 1; signd = 1; end
      2: begin size = 2; signd = 1; end
      3: begin size = 4; signd = 0; end
      4: begin size = 1; signd = 0; end
      5: begin size = 2; signd = 0; end
      6: begin size = 1; signd = 0; end
      7: begin size = 2; signd = 0; end
      8: begin size = 4; signd = 0; end
      default: begin size = 0; signd = 0; end
    endcase
    store = (op >= 6 && op <= 8);
    lane  = int'(addr % 4);
    if (size == 0) begin
      v.chk_data = 1; v.exp_data = addr; v.exp_wen = (rd != 0);
    end else if ((addr % size) != 0) begin
      v.exp_err = 1;
    end else begin
      v.exp_mem = 1;
      v.exp_we  = store;
      if (store) begin
        v.exp_wstrb = 4'(((1 << size) - 1) << lane);
        for (int b = 0; b < 4; b++) v.exp_mwdata[8*b +: 8] = wdata[8*(b % size) +: 8];
      end
      if (ack_dly > T) v.exp_err = 1;
      else if (!store) begin
        val = rdata >> (8 * lane);
        if (size == 1) begin
          val = val & 32'hFF;
          if (signd && val >= 128) val = val - 256;
        end else if (size == 2) begin
          val = val & 32'hFFFF;
          if (signd && val >= 32768) val = val - 65536;
        end
        v.chk_data = 1; v.exp_data = val; v.exp_wen = (rd != 0);
      end
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int waitc, base, exp_req;
    waitc = 0;
    while (!in_ready && waitc < 20) begin @(posedge clk); #1; waitc++; end
    check(tag, "in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1; in_op = v.op; in_addr = v.addr; in_wdata = v.wdata; in_rd = v.rd;
    base = req_cycles;
    @(posedge clk); #1;
    in_valid = 0; in_op = 4'($urandom); in_addr = $urandom; in_wdata = $urandom;
    in_rd = 5'($urandom);
    check(tag, "in_ready_busy", 32'(in_ready), 32'd0);
    if (v.exp_mem) begin
      check(tag, "early_valid", 32'(out_valid), 32'd0);
      for (int k = 1; k <= T; k++) begin
        check(tag, "mem_req", 32'(mem_req), 32'd1);
        check(tag, "mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        check(tag, "mem_we", 32'(mem_we), 32'(v.exp_we));
        check(tag, "mem_wstrb", 32'(mem_wstrb), 32'(v.exp_wstrb));
        if (v.exp_we) check(tag, "mem_wdata", mem_wdata, v.exp_mwdata);
        if (k == v.ack_dly) begin mem_ack = 1; mem_rdata = v.rdata; end
        @(posedge clk); #1;
        mem_ack = 0; mem_rdata = $urandom;
        if (k == v.ack_dly) break;
      end
      check(tag, "mem_req_drop", 32'(mem_req), 32'd0);
    end
    exp_req = v.exp_mem ? ((v.ack_dly < T) ? v.ack_dly : T) : 0;
    check(tag, "req_cycles", 32'(req_cycles - base), 32'(exp_req));
    check(tag, "out_valid", 32'(out_valid), 32'd1);
    check(tag, "out_rd", 32'(out_rd), 32'(v.rd));
    check(tag, "out_wen", 32'(out_wen), 32'(v.exp_wen));
    check(tag, "out_err", 32'(out_err), 32'(v.exp_err));
    if (v.chk_data) check(tag, "out_data", out_data, v.exp_data);
    for (int c = 0; c < v.rdy_dly; c++) begin
      mem_ack = 1'($urandom); mem_rdata = $urandom;  // stray acks must be ignored
      @(posedge clk); #1;
      mem_ack = 0;
      check(tag, "hold_valid", 32'(out_valid), 32'd1);
      check(tag, "hold_wen", 32'(out_wen), 32'(v.exp_wen));
      check(tag, "hold_err", 32'(out_err), 32'(v.exp_err));
      check(tag, "hold_in_ready", 32'(in_ready), 32'd0);
      check(tag, "hold_req", 32'(mem_req), 32'd0);
      if (v.chk_data) check(tag, "hold_data", out_data, v.exp_data);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check(tag, "valid_clear", 32'(out_valid), 32'd0);
    check(tag, "in_ready_back", 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    rst = 1; in_valid = 0; in_op = 0; in_addr = 0; in_wdata = 0; in_rd = 0;
    mem_ack = 0; mem_rdata = 0; out_ready = 0;

    vecs[0]  = '{OpNone, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 0, 0,
                 0, 0, 4'h0, 32'h0, 1, 32'h0000_1234, 1, 0};
    vecs[1]  = '{OpLb, 32'h103, 32'h0, 5'd7, 32'h80AA_BBCC, 3, 0,
                 1, 0, 4'h0, 32'h0, 1, 32'hFFFF_FF80, 1, 0};
    vecs[2]  = '{OpLhu, 32'h102, 32'h0, 5'd8, 32'h80AA_BBCC, 1, 0,
                 1, 0, 4'h0, 32'h0, 1, 32'h0000_80AA, 1, 0};
    vecs[3]  = '{OpSh, 32'h202, 32'h1234_5678, 5'd9, 32'h0, 2, 0,
                 1, 1, 4'b1100, 32'h5678_5678, 0, 32'h0, 0, 0};
    vecs[4]  = '{OpLw, 32'h301, 32'h0, 5'd10, 32'h0, 1, 0,
                 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 1};
    vecs[5]  = '{OpLw, 32'h400, 32'h0, 5'd11, 32'h55, 6, 0,
                 1, 0, 4'h0, 32'h0, 0, 32'h0, 0, 1};
    vecs[6]  = '{OpNone, 32'hDEAD_BEEF, 32'h0, 5'd0, 32'h0, 0, 5,
                 0, 0, 4'h0, 32'h0, 1, 32'hDEAD_BEEF, 0, 0};
    vecs[7]  = '{OpLh, 32'h106, 32'h0, 5'd3, 32'h8001_7FFF, 2, 1,
                 1, 0, 4'h0, 32'h0, 1, 32'hFFFF_8001, 1, 0};
    vecs[8]  = '{OpLbu, 32'h101, 32'h0, 5'd4, 32'h80AA_BBCC, 4, 0,
                 1, 0, 4'h0, 32'h0, 1, 32'h0000_00BB, 1, 0};
    vecs[9]  = '{OpSb, 32'h003, 32'h0000_00AB, 5'd1, 32'h0, 1, 0,
                 1, 1, 4'b1000, 32'hABAB_ABAB, 0, 32'h0, 0, 0};
    vecs[10] = '{OpSw, 32'h010, 32'hCAFE_F00D, 5'd2, 32'h0, 2, 5,
                 1, 1, 4'b1111, 32'hCAFE_F00D, 0, 32'h0, 0, 0};
    vecs[11] = '{OpLw, 32'h020, 32'h0, 5'd0, 32'h1122_3344, 1, 0,
                 1, 0, 4'h0, 32'h0, 1, 32'h1122_3344, 0, 0};
    vecs[12] = '{OpSh, 32'h201, 32'h1, 5'd6, 32'h0, 1, 0,
                 0, 0, 4'h0, 32'h0, 0, 32'h0, 0, 1};
    vecs[13] = '{OpLb, 32'h101, 32'h0, 5'd12, 32'h0000_7F00, 1, 0,
                 1, 0, 4'h0, 32'h0, 1, 32'h0000_007F, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset", "in_ready", 32'(in_ready), 32'd1);
    check("reset", "mem_req", 32'(mem_req), 32'd0);
    check("reset", "mem_we", 32'(mem_we), 32'd0);
    check("reset", "mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("reset", "mem_addr", mem_addr, 32'd0);
    check("reset", "mem_wdata", mem_wdata, 32'd0);
    check("reset", "out_valid", 32'(out_valid), 32'd0);
    check("reset", "out_wen", 32'(out_wen), 32'd0);
    check("reset", "out_err", 32'(out_err), 32'd0);
    check("reset", "out_data", out_data, 32'd0);
    check("reset", "out_rd", 32'(out_rd), 32'd0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while a load is waiting on memory.
    in_valid = 1; in_op = OpLw; in_addr = 32'h40; in_rd = 5'd9;
    @(posedge clk); #1;
    in_valid = 0;
    check("rst_mid", "mem_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1;
    #1;
    check("rst_mid", "mem_req_async", 32'(mem_req), 32'd0);
    check("rst_mid", "in_ready_async", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ack = 0;
    check("rst_mid", "out_valid", 32'(out_valid), 32'd0);
    check("rst_mid", "in_ready", 32'(in_ready), 32'd1);
    check("rst_mid", "mem_req", 32'(mem_req), 32'd0);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      rv = model(4'($urandom_range(0, 8)), a, $urandom, 5'($urandom),
                 $urandom, $urandom_range(1, T + 1), $urandom_range(0, 3));
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
